// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point multiplier front end:
// class codes, unpacked operand record and the skid-buffer state encoding.
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  localparam logic [2:0] FP_ZERO   = 3'd0;
  localparam logic [2:0] FP_NORM   = 3'd1;
  localparam logic [2:0] FP_DENORM = 3'd2;
  localparam logic [2:0] FP_INF    = 3'd3;
  localparam logic [2:0] FP_NAN    = 3'd4;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W:0]   man;
    logic [2:0]          cls;
  } fp_unpacked_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fp_classify.sv
// Combinational field split of one packed operand: sign, biased exponent,
// mantissa with hidden bit, and class code.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sgn,
  output logic [EXP_W-1:0]     expo,
  output logic [MAN_W:0]       man,
  output logic [2:0]           cls
);

  logic [MAN_W-1:0] frac;
  logic             exp_zero;
  logic             exp_ones;
  logic             frac_zero;

  assign sgn       = op[EXP_W+MAN_W];
  assign expo      = op[MAN_W +: EXP_W];
  assign frac      = op[MAN_W-1:0];
  assign exp_zero  = (expo == '0);
  assign exp_ones  = &expo;
  assign frac_zero = (frac == '0);
  assign man       = {!exp_zero, frac};

  always_comb begin
    cls = FP_NORM;
    if (exp_zero) begin
      cls = frac_zero ? FP_ZERO : FP_DENORM;
    end else if (exp_ones) begin
      cls = frac_zero ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/fp_unpack_stage.sv
// Operand-unpack stage: optional sign-ordering swap, per-operand classification,
// and a two-entry skid buffer whose in_ready comes straight from state flops.
module fp_unpack_stage
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] x,
  input  logic [EXP_W+MAN_W:0] y,
  input  logic                 swap_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_xs,
  output logic                 out_ys,
  output logic [EXP_W-1:0]     out_xe,
  output logic [EXP_W-1:0]     out_ye,
  output logic [MAN_W:0]       out_xm,
  output logic [MAN_W:0]       out_ym,
  output logic [2:0]           out_xcls,
  output logic [2:0]           out_ycls,
  output logic                 out_swapped
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int FW = EXP_W + MAN_W + 5;
  localparam int PW = 2 * FW + 1;

  logic             swap;
  logic [W-1:0]     op_sel [2];
  logic             sgn_c  [2];
  logic [EXP_W-1:0] exp_c  [2];
  logic [MAN_W:0]   man_c  [2];
  logic [2:0]       cls_c  [2];
  logic [PW-1:0]    pair_in;

  // Exchange only when it moves a negative x behind a positive y.
  assign swap      = swap_en && x[W-1] && !y[W-1];
  assign op_sel[0] = swap ? y : x;
  assign op_sel[1] = swap ? x : y;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cls
      fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls (
        .op   (op_sel[gi]),
        .sgn  (sgn_c[gi]),
        .expo (exp_c[gi]),
        .man  (man_c[gi]),
        .cls  (cls_c[gi])
      );
    end
  endgenerate

  assign pair_in = {sgn_c[0], exp_c[0], man_c[0], cls_c[0],
                    sgn_c[1], exp_c[1], man_c[1], cls_c[1], swap};

  buf_state_e    state_reg, state_next;
  logic [PW-1:0] main_reg;
  logic [PW-1:0] skid_reg;
  logic          accept;
  logic          pop;
  logic          load_main;
  logic          load_skid;
  logic          main_from_skid;

  assign out_valid = (state_reg != ST_EMPTY);
  assign in_ready  = (state_reg != ST_FULL);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_next     = state_reg;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) begin
          load_main  = 1'b1;
          state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = ST_FULL;
        end else if (pop) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          main_from_skid = 1'b1;
          state_next     = ST_ONE;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (load_main) begin
        main_reg <= pair_in;
      end else if (main_from_skid) begin
        main_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= pair_in;
      end
    end
  end

  assign {out_xs, out_xe, out_xm, out_xcls,
          out_ys, out_ye, out_ym, out_ycls, out_swapped} = main_reg;

endmodule

// File: tb/tb_fp_unpack_stage.sv
// Scoreboard bench for fp_unpack_stage: directed vectors, backpressure,
// random handshake, full throughput, mid-operation reset and half precision.
module tb_fp_unpack_stage;

  typedef struct packed {
    logic        xs;
    logic [7:0]  xe;
    logic [23:0] xm;
    logic [2:0]  xc;
    logic        ys;
    logic [7:0]  ye;
    logic [23:0] ym;
    logic [2:0]  yc;
    logic        sw;
  } res_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        se;
    res_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, swap_en = 1'b0;
  logic [31:0] x = '0, y = '0;
  logic        out_valid, out_ready = 1'b0;
  logic        out_xs, out_ys, out_swapped;
  logic [7:0]  out_xe, out_ye;
  logic [23:0] out_xm, out_ym;
  logic [2:0]  out_xcls, out_ycls;

  fp_unpack_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .swap_en(swap_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_xs(out_xs), .out_ys(out_ys), .out_xe(out_xe), .out_ye(out_ye),
    .out_xm(out_xm), .out_ym(out_ym), .out_xcls(out_xcls), .out_ycls(out_ycls),
    .out_swapped(out_swapped)
  );

  logic        h_valid = 1'b0, h_ready, h_out_valid;
  logic [15:0] h_x = '0, h_y = '0;
  logic        h_xs, h_ys, h_sw;
  logic [4:0]  h_xe, h_ye;
  logic [10:0] h_xm, h_ym;
  logic [2:0]  h_xc, h_yc;

  fp_unpack_stage #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_valid), .in_ready(h_ready),
    .x(h_x), .y(h_y), .swap_en(1'b0), .out_valid(h_out_valid), .out_ready(1'b1),
    .out_xs(h_xs), .out_ys(h_ys), .out_xe(h_xe), .out_ye(h_ye),
    .out_xm(h_xm), .out_ym(h_ym), .out_xcls(h_xc), .out_ycls(h_yc),
    .out_swapped(h_sw)
  );

  res_t act;
  assign act = {out_xs, out_xe, out_xm, out_xcls, out_ys, out_ye, out_ym, out_ycls, out_swapped};

  int   n_tests = 0;
  int   n_fail  = 0;
  int   accepted = 0;
  res_t sb[$];
  vec_t pend[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  function automatic logic [2:0] mcls(input logic [7:0] e, input logic [22:0] f);
    if (e == 8'h00) return (f == 0) ? 3'd0 : 3'd2;
    if (e == 8'hFF) return (f == 0) ? 3'd3 : 3'd4;
    return 3'd1;
  endfunction

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic se);
    res_t r;
    logic [31:0] p, q;
    logic s;
    s = se && a[31] && !b[31];
    p = s ? b : a;
    q = s ? a : b;
    r.xs = p[31]; r.xe = p[30:23]; r.xm = {p[30:23] != 0, p[22:0]}; r.xc = mcls(p[30:23], p[22:0]);
    r.ys = q[31]; r.ye = q[30:23]; r.ym = {q[30:23] != 0, q[22:0]}; r.yc = mcls(q[30:23], q[22:0]);
    r.sw = s;
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(3))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      default: ;
    endcase
    if ($urandom_range(3) == 0) v[22:0] = '0;
    return v;
  endfunction

  task automatic push_rand(input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.x = rand_op(); v.y = rand_op(); v.se = 1'($urandom_range(1));
      v.e = model(v.x, v.y, v.se);
      pend.push_back(v);
    end
  endtask

  // Presents pending pairs; a pair is recorded on the scoreboard at the edge that takes it.
  task automatic feed(input int vprob, input int budget);
    int  cyc;
    logic go;
    cyc = 0;
    @(posedge clk); #1;
    while (pend.size() > 0 && cyc < budget) begin
      in_valid = ($urandom_range(99) < vprob);
      x = pend[0].x; y = pend[0].y; swap_en = pend[0].se;
      @(negedge clk);
      go = in_valid && in_ready;
      @(posedge clk);
      if (go) begin
        sb.push_back(pend[0].e);
        void'(pend.pop_front());
        accepted++;
      end
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (pend.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL feed_timeout: got %0d pairs left required 0", pend.size());
      pend.delete();
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    out_ready = 1'b1;
    while (sb.size() > 0 && c < 200) begin
      @(posedge clk); c++;
    end
    @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_output: got %0h required none", act);
      end else begin
        res_t e;
        e = sb.pop_front();
        check("output", act, e);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];
  int   ir_cnt, ov_cnt, first_ov;
  logic rand_done;

  initial begin
    tbl[0] = '{32'hC0000000, 32'h3F800000, 1'b1,
               res_t'{1'b0, 8'h7F, 24'h800000, 3'd1, 1'b1, 8'h80, 24'h800000, 3'd1, 1'b1}};
    tbl[1] = '{32'hC0000000, 32'h3F800000, 1'b0,
               res_t'{1'b1, 8'h80, 24'h800000, 3'd1, 1'b0, 8'h7F, 24'h800000, 3'd1, 1'b0}};
    tbl[2] = '{32'h7F800000, 32'h7FC00000, 1'b0,
               res_t'{1'b0, 8'hFF, 24'h800000, 3'd3, 1'b0, 8'hFF, 24'hC00000, 3'd4, 1'b0}};
    tbl[3] = '{32'h00000001, 32'h80000000, 1'b1,
               res_t'{1'b0, 8'h00, 24'h000001, 3'd2, 1'b1, 8'h00, 24'h000000, 3'd0, 1'b0}};
    tbl[4] = '{32'hBF800000, 32'hC0000000, 1'b1,
               res_t'{1'b1, 8'h7F, 24'h800000, 3'd1, 1'b1, 8'h80, 24'h800000, 3'd1, 1'b0}};
    tbl[5] = '{32'h00800000, 32'h7F7FFFFF, 1'b0,
               res_t'{1'b0, 8'h01, 24'h800000, 3'd1, 1'b0, 8'hFE, 24'hFFFFFF, 3'd1, 1'b0}};

    // Reset state
    #3 rst = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_outputs", act, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Half precision
    @(posedge clk); #1;
    h_x = 16'h3C00; h_y = 16'h7C01; h_valid = 1'b1;
    @(posedge clk); #1;
    h_valid = 1'b0;
    @(negedge clk);
    check("half_valid", h_out_valid, 1);
    check("half_xe", h_xe, 5'h0F);
    check("half_xm", h_xm, 11'h400);
    check("half_xcls", h_xc, 3'd1);
    check("half_ycls", h_yc, 3'd4);

    // Directed vectors, streamed back to back
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) pend.push_back(tbl[i]);
    feed(100, 50);
    drain();

    // Full throughput with latency 1
    push_rand(20);
    ir_cnt = 0; ov_cnt = 0; first_ov = -1;
    fork
      feed(100, 60);
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 22; i++) begin
          @(negedge clk);
          if (in_ready) ir_cnt++;
          if (out_valid) begin
            ov_cnt++;
            if (first_ov < 0) first_ov = i;
          end
        end
      end
    join
    check("thru_in_ready", ir_cnt, 22);
    check("thru_out_count", ov_cnt, 20);
    check("thru_latency", first_ov, 1);
    drain();

    // Backpressure: out_ready drops after two cycles
    push_rand(8);
    accepted = 0;
    fork
      feed(100, 100);
      begin
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_held", sb.size(), 2);
        check("bp_accepted", accepted, 3);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    drain();

    // Random valid/ready
    push_rand(1000);
    rand_done = 1'b0;
    fork
      begin
        feed(60, 20000);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(1));
        end
      end
    join
    drain();

    // Reset while FULL
    out_ready = 1'b0;
    push_rand(2);
    feed(100, 20);
    @(negedge clk);
    check("pre_reset_in_ready", in_ready, 0);
    #2 rst = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_outputs", act, 0);
    check("midreset_in_ready", in_ready, 1);
    sb.delete();
    in_valid = 1'b1; x = 32'h3F800000; y = 32'h3F800000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("reset_ignores_input", out_valid, 0);
    @(negedge clk) rst = 1'b1;
    out_ready = 1'b1;
    push_rand(1);
    feed(100, 10);
    @(negedge clk);
    check("post_reset_latency", out_valid, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
